// File: rtl/motor_plant_model.sv
// motor_plant_model: plant model of a two-limit linear actuator.
// Integrates motor_up/motor_dn drive commands into a position counter.
// A prescaler of STEP_DIV clocks paces each step. up_limit, dn_limit and
// overrun are registered; moving and fault decode the state register.
// state_dbg exposes the FSM state for checkers.
// Optional build macro MOTOR_PLANT_COAST_EN: when neither command is
// asserted while moving, the plant coasts to the end of the current
// prescaler period. It then takes one last step and stops.
module motor_plant_model #(
    parameter int TRAVEL   = 16,
    parameter int STEP_DIV = 4,
    parameter int INIT_POS = 0,
    parameter int POS_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             motor_up,
    input  logic             motor_dn,
    output logic             up_limit,
    output logic             dn_limit,
    output logic [POS_W-1:0] position,
    output logic             moving,
    output logic             fault,
    output logic             overrun,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

`ifdef MOTOR_PLANT_COAST_EN
    localparam logic COAST = 1'b1;
`else
    localparam logic COAST = 1'b0;
`endif

    typedef enum logic [1:0] {
        STOPPED   = 2'd0,
        MOVING_UP = 2'd1,
        MOVING_DN = 2'd2,
        FAULT     = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic             ovr_nxt;
    logic             up_lim_nxt;
    logic             dn_lim_nxt;

    logic cmd_u;
    logic cmd_d;
    logic cmd_b;
    logic cmd_n;
    logic hold_up;
    logic hold_dn;

    // Decode the two drive lines into exactly one of U / D / B / N.
    always_comb begin
        cmd_u = motor_up & ~motor_dn;
        cmd_d = motor_dn & ~motor_up;
        cmd_b = motor_up & motor_dn;
        cmd_n = ~motor_up & ~motor_dn;
        // With coasting enabled, N keeps the prescaler running in the
        // current direction until the period completes.
        hold_up = cmd_u | (COAST & cmd_n);
        hold_dn = cmd_d | (COAST & cmd_n);
    end

    // Next-state, prescaler, position and sticky overrun logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pos_nxt   = position;
        ovr_nxt   = overrun;

        case (state)
            STOPPED: begin
                cnt_nxt = '0;
                if (cmd_u) begin
                    state_nxt = MOVING_UP;
                end else if (cmd_d) begin
                    state_nxt = MOVING_DN;
                end else if (cmd_b) begin
                    state_nxt = FAULT;
                end
            end

            MOVING_UP: begin
                if (hold_up) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        if (position < POS_TOP) begin
                            pos_nxt = position + POS_ONE;
                        end else begin
                            ovr_nxt = 1'b1;
                        end
                        // A coasting plant stops after its final step.
                        if (cmd_n) begin
                            state_nxt = STOPPED;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else if (cmd_d) begin
                    state_nxt = MOVING_DN;
                    cnt_nxt   = '0;
                end else if (cmd_b) begin
                    state_nxt = FAULT;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = STOPPED;
                    cnt_nxt   = '0;
                end
            end

            MOVING_DN: begin
                if (hold_dn) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        if (position != '0) begin
                            pos_nxt = position - POS_ONE;
                        end else begin
                            ovr_nxt = 1'b1;
                        end
                        if (cmd_n) begin
                            state_nxt = STOPPED;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else if (cmd_u) begin
                    state_nxt = MOVING_UP;
                    cnt_nxt   = '0;
                end else if (cmd_b) begin
                    state_nxt = FAULT;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = STOPPED;
                    cnt_nxt   = '0;
                end
            end

            FAULT: begin
                // Position is frozen; only a full release clears the fault.
                cnt_nxt = '0;
                if (cmd_n) begin
                    state_nxt = STOPPED;
                end
            end

            default: begin
                state_nxt = STOPPED;
                cnt_nxt   = '0;
            end
        endcase

        // Limits follow the new position so they change on the same edge.
        up_lim_nxt = (pos_nxt == POS_TOP);
        dn_lim_nxt = (pos_nxt == '0);
    end

    // State, prescaler, position, limit and overrun registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOPPED;
            cnt      <= '0;
            position <= POS_INIT;
            up_limit <= (INIT_POS == TRAVEL);
            dn_limit <= (INIT_POS == 0);
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            position <= pos_nxt;
            up_limit <= up_lim_nxt;
            dn_limit <= dn_lim_nxt;
            overrun  <= ovr_nxt;
        end
    end

    // Status flags decode directly from the registered state.
    always_comb begin
        moving    = (state == MOVING_UP) || (state == MOVING_DN);
        fault     = (state == FAULT);
        state_dbg = state;
    end

endmodule

// File: tb/tb_motor_plant_model.sv
// Directed testbench for motor_plant_model.
// dut1 uses the default parameters (INIT_POS=0). dut2 shares clock,
// reset and commands but is built with INIT_POS=16, so that reset values
// at the top of travel can be checked.
// Edge numbers in comments count rising edges after the first edge that
// samples a command.
module tb_motor_plant_model;

    logic       clk;
    logic       rst;
    logic       motor_up;
    logic       motor_dn;

    logic       up_limit1, dn_limit1, moving1, fault1, overrun1;
    logic [4:0] position1;
    logic [1:0] state1;

    logic       up_limit2, dn_limit2, moving2, fault2, overrun2;
    logic [4:0] position2;
    logic [1:0] state2;

    int checks   = 0;
    int failures = 0;
    int exp_pos  = 0;

    motor_plant_model #(
        .TRAVEL(16), .STEP_DIV(4), .INIT_POS(0), .POS_W(5)
    ) dut1 (
        .clk(clk), .rst(rst), .motor_up(motor_up), .motor_dn(motor_dn),
        .up_limit(up_limit1), .dn_limit(dn_limit1), .position(position1),
        .moving(moving1), .fault(fault1), .overrun(overrun1),
        .state_dbg(state1)
    );

    motor_plant_model #(
        .TRAVEL(16), .STEP_DIV(4), .INIT_POS(16), .POS_W(5)
    ) dut2 (
        .clk(clk), .rst(rst), .motor_up(motor_up), .motor_dn(motor_dn),
        .up_limit(up_limit2), .dn_limit(dn_limit2), .position(position2),
        .moving(moving2), .fault(fault2), .overrun(overrun2),
        .state_dbg(state2)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        motor_up = 1'b0;
        motor_dn = 1'b0;
        run(2);

        // Reset state of both builds.
        chk("rst_pos1",     int'(position1), 0);
        chk("rst_dnlim1",   int'(dn_limit1), 1);
        chk("rst_uplim1",   int'(up_limit1), 0);
        chk("rst_moving1",  int'(moving1),   0);
        chk("rst_fault1",   int'(fault1),    0);
        chk("rst_overrun1", int'(overrun1),  0);
        chk("rst_state1",   int'(state1),    0);
        chk("rst_pos2",     int'(position2), 16);
        chk("rst_uplim2",   int'(up_limit2), 1);
        chk("rst_dnlim2",   int'(dn_limit2), 0);

        // Hold U from the bottom: position k lands at edge 1+4k.
        rst      = 1'b0;
        motor_up = 1'b1;
        run(1);
        chk("up_e1_moving", int'(moving1), 1);
        chk("up_e1_pos",    int'(position1), 0);
        run(3);
        chk("up_e4_pos",    int'(position1), 0);
        chk("up_e4_dnlim",  int'(dn_limit1), 1);
        run(1);
        chk("up_e5_pos",    int'(position1), 1);
        chk("up_e5_dnlim",  int'(dn_limit1), 0);
        chk("up_e5_ovr2",   int'(overrun2),  1);
        chk("up_e5_pos2",   int'(position2), 16);
        run(59);
        chk("up_e64_pos",   int'(position1), 15);
        chk("up_e64_uplim", int'(up_limit1), 0);
        run(1);
        chk("up_e65_pos",   int'(position1), 16);
        chk("up_e65_uplim", int'(up_limit1), 1);
        chk("up_e65_ovr",   int'(overrun1),  0);
        run(3);
        chk("up_e68_ovr",   int'(overrun1),  0);
        run(1);
        chk("up_e69_ovr",   int'(overrun1),  1);
        chk("up_e69_pos",   int'(position1), 16);

        // Release at the top.
        motor_up = 1'b0;
`ifdef MOTOR_PLANT_COAST_EN
        run(1);
        chk("rel_coast_moving", int'(moving1), 1);
        run(3);
`else
        run(1);
`endif
        chk("rel_moving",  int'(moving1),   0);
        chk("rel_state",   int'(state1),    0);
        chk("rel_pos",     int'(position1), 16);
        chk("rel_ovr",     int'(overrun1),  1);

        // D for 9 edges from 16, then release.
        motor_dn = 1'b1;
        run(9);
        chk("dn9_pos",     int'(position1), 14);
        chk("dn9_uplim",   int'(up_limit1), 0);
        motor_dn = 1'b0;
        run(1);
`ifdef MOTOR_PLANT_COAST_EN
        chk("dnrel_coast_moving", int'(moving1), 1);
        chk("dnrel_coast_pos",    int'(position1), 14);
        run(3);
        exp_pos = 13;
`else
        exp_pos = 14;
`endif
        chk("dnrel_moving", int'(moving1),   0);
        chk("dnrel_pos",    int'(position1), exp_pos);
        chk("dnrel_ovr",    int'(overrun1),  1);

        // Both commands while moving -> FAULT with frozen position.
        motor_up = 1'b1;
        run(2);
        chk("flt_pre_moving", int'(moving1), 1);
        motor_dn = 1'b1;
        run(1);
        chk("flt_fault",   int'(fault1),    1);
        chk("flt_moving",  int'(moving1),   0);
        chk("flt_pos",     int'(position1), exp_pos);
        run(5);
        chk("flt_hold_pos",   int'(position1), exp_pos);
        chk("flt_hold_fault", int'(fault1),    1);
        motor_dn = 1'b0;
        run(1);
        chk("flt_u_only",  int'(fault1),    1);
        chk("flt_u_pos",   int'(position1), exp_pos);
        motor_up = 1'b0;
        run(1);
        chk("flt_exit_fault", int'(fault1),    0);
        chk("flt_exit_state", int'(state1),    0);
        chk("flt_exit_pos",   int'(position1), exp_pos);

        // Reset pulse clears the sticky overrun.
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        chk("rst2_pos1",  int'(position1), 0);
        chk("rst2_ovr1",  int'(overrun1),  0);
        chk("rst2_pos2",  int'(position2), 16);

        // Reversal: U for 6 edges, then D; position 0 five edges later.
        motor_up = 1'b1;
        run(6);
        chk("rev_e6_pos", int'(position1), 1);
        motor_up = 1'b0;
        motor_dn = 1'b1;
        run(1);
        chk("rev_sw_state", int'(state1),    2);
        chk("rev_sw_pos",   int'(position1), 1);
        run(3);
        chk("rev_e10_pos",  int'(position1), 1);
        run(1);
        chk("rev_e11_pos",   int'(position1), 0);
        chk("rev_e11_dnlim", int'(dn_limit1), 1);
        chk("rev_e11_ovr",   int'(overrun1),  0);
        chk("rev_ovr2",      int'(overrun2),  1);
        run(4);
        chk("rev_bot_ovr",  int'(overrun1),  1);
        chk("rev_bot_pos",  int'(position1), 0);
        chk("rev_moving2",  int'(moving2),   1);

        // Reset mid-motion with D still asserted.
        rst = 1'b1;
        run(1);
        chk("mid_rst_pos1",    int'(position1), 0);
        chk("mid_rst_ovr1",    int'(overrun1),  0);
        chk("mid_rst_moving1", int'(moving1),   0);
        chk("mid_rst_pos2",    int'(position2), 16);
        chk("mid_rst_uplim2",  int'(up_limit2), 1);
        chk("mid_rst_dnlim2",  int'(dn_limit2), 0);
        chk("mid_rst_moving2", int'(moving2),   0);
        chk("mid_rst_ovr2",    int'(overrun2),  0);
        chk("mid_rst_fault2",  int'(fault2),    0);
        rst      = 1'b0;
        motor_dn = 1'b0;
        run(2);
        chk("idle_moving2", int'(moving2),   0);
        chk("idle_pos2",    int'(position2), 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
